// File: rtl/spi_master_m.sv
// SPI mode-0 master: 8-bit, LSB-first transfers with CS framing, for use with spi_slave_m.
// SCK half-period is CLK_DIV system clocks; RX_DATA is updated only when DONE pulses.
module spi_master_m #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       done,
   output logic       cs,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] idx_next;
   logic       sck_q, sck_d;
   logic       cs_q, cs_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       div_last;

   assign div_last  = (div_q == DIV_LAST);
   assign idx_next  = idx_q + 3'd1;

   assign rx_data   = rx_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cs        = cs_q;
   assign sck       = sck_q;
   assign mosi      = mosi_q;
   assign fsm_state = state_q;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      idx_d     = idx_q;
      sck_d     = sck_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               tx_d    = tx_data;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               mosi_d  = tx_data[0];
               div_d   = 8'd0;
               idx_d   = 3'd0;
               state_d = SETUP;
            end
         end

         SETUP: begin
            if (div_last) begin
               div_d   = 8'd0;
               sck_d   = 1'b1;
               rx_d[0] = miso;
               state_d = XFER;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         XFER: begin
            if (div_last) begin
               div_d = 8'd0;
               if (!sck_q) begin
                  sck_d       = 1'b1;
                  rx_d[idx_q] = miso;
               end else begin
                  sck_d = 1'b0;
                  // Last falling edge leaves MOSI on bit 7 through HOLD.
                  if (idx_q != 3'd7) begin
                     idx_d  = idx_next;
                     mosi_d = tx_q[idx_next];
                  end else begin
                     state_d = HOLD;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         HOLD: begin
            if (div_last) begin
               div_d     = 8'd0;
               cs_d      = 1'b1;
               mosi_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_q;
               state_d   = IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset wins over everything, so an aborted transfer raises CS without DONE.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         div_q     <= 8'd0;
         idx_q     <= 3'd0;
         sck_q     <= 1'b0;
         cs_q      <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tx_q      <= 8'd0;
         rx_q      <= 8'd0;
         rx_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         sck_q     <= sck_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
      end
   end

endmodule

// File: doc/spi_master_m.md
SPI_MASTER_M -- requirements
Module: spi_master_m

Interface
REQ-001 Parameter CLK_DIV, default 2, CLK cycles per SCK half-period; legal range 1..255.
REQ-002 CLK  input  1  system clock; all logic on its rising edge.
REQ-003 RSTN  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  transfer request, sampled each CLK edge.
REQ-005 TX_DATA  input  8  byte to send, captured when START is accepted.
REQ-006 RX_DATA  output  8  last received byte, updated at transfer end.
REQ-007 BUSY  output  1  high from START acceptance until the DONE edge.
REQ-008 DONE  output  1  one-CLK pulse marking transfer completion.
REQ-009 CS  output  1  active-low chip select to an spi_slave_m.
REQ-010 SCK  output  1  serial clock, idle low.
REQ-011 MOSI  output  1  serial data to slave.
REQ-012 MISO  input  1  serial data from slave.

Function
REQ-013 The block SHALL implement SPI mode 0, 8 bits, LSB first, matching spi_slave_m: slave samples MOSI on SCK rise and advances its bit index on SCK fall.
REQ-014 FSM states SHALL be IDLE, SETUP, XFER, HOLD; an 8-bit divider counter and a 3-bit bit index SHALL time every state.
REQ-015 IDLE: CS=1, SCK=0, BUSY=0; START=1 at edge E0 SHALL latch TX_DATA, drive CS=0, BUSY=1, MOSI=TX_DATA[0], clear the divider and bit index, and enter SETUP.
REQ-016 SETUP SHALL last CLK_DIV cycles; at edge E0+CLK_DIV it SHALL drive SCK=1, sample MISO into rx bit 0, and enter XFER.
REQ-017 XFER SHALL toggle SCK every CLK_DIV cycles.
REQ-018 On each SCK rise, the block SHALL sample MISO into rx[index].
REQ-019 On each SCK fall with index<7, the block SHALL increment index and drive MOSI=tx[index+1].
REQ-020 On the SCK fall with index=7 (edge E0+16*CLK_DIV), the block SHALL enter HOLD with SCK=0 and MOSI unchanged.
REQ-021 HOLD SHALL last CLK_DIV cycles; at edge E0+17*CLK_DIV it SHALL drive CS=1, MOSI=0, BUSY=0, DONE=1, load RX_DATA from rx, and enter IDLE.
REQ-022 Each transfer SHALL produce exactly 8 SCK rising edges, all with CS=0.
REQ-023 DONE SHALL be high for exactly one cycle per completed transfer.
REQ-024 START SHALL be ignored while BUSY=1; TX_DATA changes during a transfer SHALL have no effect.
REQ-025 START=1 in the DONE cycle SHALL be accepted (state is IDLE), giving back-to-back transfers with CS high for exactly one CLK cycle.
REQ-026 RX_DATA SHALL hold its value between transfers and SHALL change only on the DONE edge.
REQ-027 With CLK_DIV=1, SCK SHALL toggle every CLK cycle and DONE SHALL occur at E0+17.

Reset
REQ-028 RSTN=0 at any CLK edge SHALL force IDLE, CS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, and clear the divider, index and shift registers.
REQ-029 Reset mid-transfer SHALL abort without a DONE pulse; CS SHALL rise on that same edge so the slave index restarts on the next CS fall.
REQ-030 START asserted while RSTN=0 SHALL be ignored.

Verification
REQ-031 Reset: RSTN=0 for 2 cycles -> CS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0x00.
REQ-032 Basic, with spi_slave_m attached: CLK_DIV=2, TX_DATA=0xA5, slave DOUT=0x3C -> slave DIN=0xA5, RX_DATA=0x3C, 8 SCK rises, DONE at E0+34.
REQ-033 Busy ignore: START with 0x12, then START with 0xFF at E0+5 -> slave DIN=0x12, one DONE only.
REQ-034 Back-to-back: START held high through DONE, TX 0x01 then 0x80 -> CS high exactly 1 cycle between transfers, slave DIN=0x80 after second DONE.
REQ-035 Abort: RSTN=0 after 3rd SCK rise -> CS=1, SCK=0 next edge, no DONE; then START with 0x81 -> slave DIN=0x81.
REQ-036 Fast clock: CLK_DIV=1, TX 0xFF, DOUT 0x00 -> RX_DATA=0x00, slave DIN=0xFF, DONE at E0+17.
